// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Result-broadcast side of the common data bus. Each functional unit owns
// one holding slot. A round-robin arbiter picks one source per cycle, and the
// chosen result is driven onto a registered broadcast (cdb_*) that the
// reservation stations use for wakeup.
//
// Optional feature macro: CDB_BYPASS_EN
//   defined   : an FU whose slot is empty may be granted straight from its
//               inputs, so the result does not pass through the slot.
//   undefined : only occupied slots compete, and every result is held in its
//               slot for one cycle first.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   fu_done    in   [NUM_FU]         FU i presents a result
//   fu_tag     in   [NUM_FU*PREG_W]  destination tag, slice i
//   fu_value   in   [NUM_FU*XLEN]    result value, slice i
//   fu_ack     out  [NUM_FU]         result i accepted this cycle (combinational)
//   squash     in   flush all pending results
//   cdb_ready  out  broadcast valid, one pulse per result
//   cdb_tag    out  [PREG_W] broadcast tag
//   cdb_value  out  [XLEN]   broadcast value
//   cdb_src    out  index of the granted FU
module cdb_arbiter #(
   parameter  int NUM_FU = 5,
   parameter  int PREG_W = 6,
   parameter  int XLEN   = 32,
   localparam int SRC_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_FU-1:0]        fu_done,
   input  logic [NUM_FU*PREG_W-1:0] fu_tag,
   input  logic [NUM_FU*XLEN-1:0]   fu_value,
   output logic [NUM_FU-1:0]        fu_ack,
   input  logic                     squash,
   output logic                     cdb_ready,
   output logic [PREG_W-1:0]        cdb_tag,
   output logic [XLEN-1:0]          cdb_value,
   output logic [SRC_W-1:0]         cdb_src
);

   logic [NUM_FU-1:0] r_slot_valid;
   logic [PREG_W-1:0] r_slot_tag   [NUM_FU];
   logic [XLEN-1:0]   r_slot_value [NUM_FU];
   logic [SRC_W-1:0]  r_rr_ptr;

   logic [NUM_FU-1:0] w_elig;
   logic [NUM_FU-1:0] w_grant;
   logic [NUM_FU-1:0] w_byp;
   logic              w_any_grant;
   logic [SRC_W-1:0]  w_grant_idx;
   logic [PREG_W-1:0] w_sel_tag;
   logic [XLEN-1:0]   w_sel_value;

   // With bypass, valid | (done & ~valid) reduces to valid | done.
   always_comb begin
`ifdef CDB_BYPASS_EN
      w_elig = r_slot_valid | fu_done;
`else
      w_elig = r_slot_valid;
`endif
   end

   // Round-robin scan starting at r_rr_ptr; squash suppresses every grant.
   always_comb begin : p_arb
      int v_idx;
      v_idx       = 0;
      w_grant     = '0;
      w_any_grant = 1'b0;
      w_grant_idx = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         v_idx = int'(r_rr_ptr) + k;
         if (v_idx >= NUM_FU) v_idx = v_idx - NUM_FU;
         if (!w_any_grant && !squash && w_elig[v_idx]) begin
            w_any_grant    = 1'b1;
            w_grant[v_idx] = 1'b1;
            w_grant_idx    = SRC_W'(v_idx);
         end
      end
   end

   // A grant to an empty slot can only be a bypass grant.
   always_comb begin
`ifdef CDB_BYPASS_EN
      w_byp = w_grant & ~r_slot_valid;
`else
      w_byp = '0;
`endif
   end

   // A granted full slot frees up this cycle, so its FU may refill it at once.
   assign fu_ack = fu_done & ~{NUM_FU{squash}} & (~r_slot_valid | w_grant);

   // Zero when nothing is granted, which gives the idle value of the bus.
   always_comb begin
      w_sel_tag   = '0;
      w_sel_value = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (w_grant[i]) begin
            if (w_byp[i]) begin
               w_sel_tag   = fu_tag[i*PREG_W +: PREG_W];
               w_sel_value = fu_value[i*XLEN +: XLEN];
            end else begin
               w_sel_tag   = r_slot_tag[i];
               w_sel_value = r_slot_value[i];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_slot_valid <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            r_slot_tag[i]   <= '0;
            r_slot_value[i] <= '0;
         end
      end else if (squash) begin
         r_slot_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_ack[i] && !w_byp[i]) begin
               r_slot_valid[i] <= 1'b1;
               r_slot_tag[i]   <= fu_tag[i*PREG_W +: PREG_W];
               r_slot_value[i] <= fu_value[i*XLEN +: XLEN];
            end else if (w_grant[i]) begin
               r_slot_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rr_ptr  <= '0;
         cdb_ready <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
      end else begin
         if (w_any_grant) begin
            r_rr_ptr <= (w_grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : w_grant_idx + 1'b1;
         end
         cdb_ready <= w_any_grant;
         cdb_tag   <= w_sel_tag;
         cdb_value <= w_sel_value;
         cdb_src   <= w_grant_idx;
      end
   end

endmodule
